// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_stall_controller_pkg;

   // Sequencer state: normal flow, or frozen waiting on the iterative divider
   typedef enum logic {
      RUN      = 1'b0,
      DIV_WAIT = 1'b1
   } state_t;

   // ADDI x0,x0,0 is what a flushed or bubbled pipeline register holds
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // x0 is hardwired to zero, so a write to it never creates a dependency
   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard inputs and pipeline-register controls between the stall sequencer and the datapath.
// Latency: n/a (wiring only).
// Backpressure: the controller's enables are the backpressure into the pipeline stages.
interface pipeline_stall_controller_if #(
   parameter int STALL_CNT_W = 16
);
   // hazard information from ID and EX
   logic [4:0]             ID_rs1;
   logic [4:0]             ID_rs2;
   logic                   ID_uses_rs1;
   logic                   ID_uses_rs2;
   logic [4:0]             EX_dest;
   logic                   EX_mem_read;
   logic                   EX_is_div;
   logic                   EX_branch_taken;
   logic                   div_done;
   // pipeline register controls
   logic                   pc_write_en;
   logic                   IF_ID_write_en;
   logic                   IF_ID_flush;
   logic                   ID_EX_write_en;
   logic                   ID_EX_bubble;
   logic                   EX_MEM_bubble;
   logic                   div_start;
   logic                   div_timeout;
   logic [STALL_CNT_W-1:0] stall_cycles;

   // controller side
   modport master (
      input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, EX_dest, EX_mem_read,
             EX_is_div, EX_branch_taken, div_done,
      output pc_write_en, IF_ID_write_en, IF_ID_flush, ID_EX_write_en,
             ID_EX_bubble, EX_MEM_bubble, div_start, div_timeout, stall_cycles
   );

   // pipeline/datapath side
   modport slave (
      output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, EX_dest, EX_mem_read,
             EX_is_div, EX_branch_taken, div_done,
      input  pc_write_en, IF_ID_write_en, IF_ID_flush, ID_EX_write_en,
             ID_EX_bubble, EX_MEM_bubble, div_start, div_timeout, stall_cycles
   );
endinterface

// File: rtl/pipeline_stall_controller_load_use_detector.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
// Latency: purely combinational, same cycle.
// Backpressure: none; the caller turns the flag into a stall.
module load_use_detector
   import pipeline_stall_controller_pkg::*;
(
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       uses_rs1,
   input  logic       uses_rs2,
   input  logic [4:0] ex_dest,
   input  logic       ex_mem_read,
   output logic       load_use
);

   // operands that are not actually read, and loads to x0, never need the bubble
   always_comb begin
      load_use = ex_mem_read && (ex_dest != REG_ZERO) &&
                 ((uses_rs1 && (rs1 == ex_dest)) || (uses_rs2 && (rs2 == ex_dest)));
   end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: load-use bubble, divider freeze with watchdog, branch flush, stall counter.
// Latency: controls are combinational from state and inputs; they act at the next clock edge.
// Backpressure: drops pc/IF_ID/ID_EX enables to hold the front end; EX_MEM bubble covers the divider wait.
module pipeline_stall_controller
   import pipeline_stall_controller_pkg::*;
#(
   parameter int MAX_DIV_CYCLES = 40,
   parameter int STALL_CNT_W    = 16
) (
   input logic                          clk,
   input logic                          reset,
   pipeline_stall_controller_if.master  bus
);

   localparam int                WAIT_W    = $clog2(MAX_DIV_CYCLES + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_DIV_CYCLES - 1);

   state_t                 state;
   state_t                 state_nxt;
   logic [WAIT_W-1:0]      wait_cnt;
   logic [WAIT_W-1:0]      wait_nxt;
   logic                   timeout_set;
   logic                   timeout_q;
   logic [STALL_CNT_W-1:0] stall_cnt;
   logic                   load_use;

   logic pc_we;
   logic ifid_we;
   logic ifid_flush;
   logic idex_we;
   logic idex_bubble;
   logic exmem_bubble;
   logic start;

   load_use_detector u_load_use (
      .rs1         (bus.ID_rs1),
      .rs2         (bus.ID_rs2),
      .uses_rs1    (bus.ID_uses_rs1),
      .uses_rs2    (bus.ID_uses_rs2),
      .ex_dest     (bus.EX_dest),
      .ex_mem_read (bus.EX_mem_read),
      .load_use    (load_use)
   );

   // state, divider wait counter, sticky watchdog flag and saturating stall counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RUN;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (timeout_set) begin
            timeout_q <= 1'b1;
         end
         if (!pc_we && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

   // next state: a divide with no same-cycle result enters the wait; the wait ends on done or watchdog
   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      timeout_set = 1'b0;
      unique case (state)
         RUN: begin
            if (!bus.EX_branch_taken && bus.EX_is_div && !bus.div_done) begin
               state_nxt = DIV_WAIT;
               wait_nxt  = '0;
            end
         end
         DIV_WAIT: begin
            if (bus.div_done) begin
               state_nxt = RUN;
            end else if (wait_cnt == WAIT_LAST) begin
               state_nxt   = RUN;
               timeout_set = 1'b1;
            end else begin
               wait_nxt = wait_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // pipeline controls; branch beats divide beats load-use, and the wait ignores both
   always_comb begin
      pc_we        = 1'b1;
      ifid_we      = 1'b1;
      ifid_flush   = 1'b0;
      idex_we      = 1'b1;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      start        = 1'b0;
      if (!reset) begin
         pc_we        = 1'b0;
         ifid_we      = 1'b0;
         idex_bubble  = 1'b1;
         exmem_bubble = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               if (bus.EX_branch_taken) begin
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
               end else if (bus.EX_is_div) begin
                  start = 1'b1;
                  // a result already available this cycle releases immediately
                  if (!bus.div_done) begin
                     pc_we        = 1'b0;
                     ifid_we      = 1'b0;
                     idex_we      = 1'b0;
                     exmem_bubble = 1'b1;
                  end
               end else if (load_use) begin
                  pc_we       = 1'b0;
                  ifid_we     = 1'b0;
                  idex_bubble = 1'b1;
               end
            end
            DIV_WAIT: begin
               // release cycle keeps the defaults so EX/MEM captures the quotient
               if (!bus.div_done && (wait_cnt != WAIT_LAST)) begin
                  pc_we        = 1'b0;
                  ifid_we      = 1'b0;
                  idex_we      = 1'b0;
                  exmem_bubble = 1'b1;
               end
            end
            default: begin
               pc_we = 1'b1;
            end
         endcase
      end
   end

   assign bus.pc_write_en    = pc_we;
   assign bus.IF_ID_write_en = ifid_we;
   assign bus.IF_ID_flush    = ifid_flush;
   assign bus.ID_EX_write_en = idex_we;
   assign bus.ID_EX_bubble   = idex_bubble;
   assign bus.EX_MEM_bubble  = exmem_bubble;
   assign bus.div_start      = start;
   assign bus.div_timeout    = timeout_q;
   assign bus.stall_cycles   = stall_cnt;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: two controllers (normal and short watchdog) driven by directed vectors.
// Latency: expectations are pushed when a vector is applied and popped at the following falling edge.
// Backpressure: n/a.
module tb_pipeline_stall_controller;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] dest;
      logic       mr;
      logic       dv;
      logic       br;
      logic       dn;
   } in_t;

   typedef struct packed {
      logic pc;
      logic ifwe;
      logic flush;
      logic idwe;
      logic idbub;
      logic exbub;
      logic start;
      logic tmo;
   } out_t;

   typedef struct {
      string      name;
      out_t       o;
      logic [15:0] st;
   } exp_t;

   localparam out_t O_NORM = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam out_t O_RST  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam out_t O_LU   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam out_t O_BR   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam out_t O_DST  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam out_t O_FRZ  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam in_t  I_IDLE = '0;

   logic clk;
   logic reset;

   pipeline_stall_controller_if #(.STALL_CNT_W(16)) ifa ();
   pipeline_stall_controller_if #(.STALL_CNT_W(16)) ifb ();

   pipeline_stall_controller #(.MAX_DIV_CYCLES(40), .STALL_CNT_W(16)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   pipeline_stall_controller #(.MAX_DIV_CYCLES(8), .STALL_CNT_W(16)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   exp_t        q_a[$];
   exp_t        q_b[$];
   int          total;
   int          bad;
   logic [15:0] stall_a;
   logic [15:0] stall_b;
   logic        tmo_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic in_t mi(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                              input logic u2, input logic [4:0] dest, input logic mr,
                              input logic dv, input logic br, input logic dn);
      in_t r;
      r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.dest = dest;
      r.mr = mr; r.dv = dv; r.br = br; r.dn = dn;
      return r;
   endfunction

   task automatic drive_a(input in_t v);
      ifa.ID_rs1 = v.rs1; ifa.ID_rs2 = v.rs2; ifa.ID_uses_rs1 = v.u1; ifa.ID_uses_rs2 = v.u2;
      ifa.EX_dest = v.dest; ifa.EX_mem_read = v.mr; ifa.EX_is_div = v.dv;
      ifa.EX_branch_taken = v.br; ifa.div_done = v.dn;
   endtask

   task automatic drive_b(input in_t v);
      ifb.ID_rs1 = v.rs1; ifb.ID_rs2 = v.rs2; ifb.ID_uses_rs1 = v.u1; ifb.ID_uses_rs2 = v.u2;
      ifb.EX_dest = v.dest; ifb.EX_mem_read = v.mr; ifb.EX_is_div = v.dv;
      ifb.EX_branch_taken = v.br; ifb.div_done = v.dn;
   endtask

   // apply one cycle of stimulus and queue the expected controls for each controller
   task automatic step(input string nm, input logic rst, input in_t ia, input in_t ib,
                       input out_t ea, input out_t eb);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst;
      drive_a(ia);
      drive_b(ib);
      if (!rst) begin
         stall_a = '0;
         stall_b = '0;
         tmo_b   = 1'b0;
      end
      e.name = nm; e.o = ea; e.st = stall_a;
      q_a.push_back(e);
      eb.tmo = tmo_b;
      e.name = nm; e.o = eb; e.st = stall_b;
      q_b.push_back(e);
      if (rst && !ea.pc) stall_a = stall_a + 16'd1;
      if (rst && !eb.pc) stall_b = stall_b + 16'd1;
   endtask

   // monitor: compare whatever the controllers present against the oldest queued expectation
   always @(negedge clk) begin
      exp_t e;
      out_t g;
      if (q_a.size() > 0) begin
         e = q_a.pop_front();
         g = {ifa.pc_write_en, ifa.IF_ID_write_en, ifa.IF_ID_flush, ifa.ID_EX_write_en,
              ifa.ID_EX_bubble, ifa.EX_MEM_bubble, ifa.div_start, ifa.div_timeout};
         total = total + 1;
         if (g !== e.o) begin
            bad = bad + 1;
            $display("FAIL a:%s ctl got=%b want=%b", e.name, g, e.o);
         end
         total = total + 1;
         if (ifa.stall_cycles !== e.st) begin
            bad = bad + 1;
            $display("FAIL a:%s stall got=%0d want=%0d", e.name, ifa.stall_cycles, e.st);
         end
      end
      if (q_b.size() > 0) begin
         e = q_b.pop_front();
         g = {ifb.pc_write_en, ifb.IF_ID_write_en, ifb.IF_ID_flush, ifb.ID_EX_write_en,
              ifb.ID_EX_bubble, ifb.EX_MEM_bubble, ifb.div_start, ifb.div_timeout};
         total = total + 1;
         if (g !== e.o) begin
            bad = bad + 1;
            $display("FAIL b:%s ctl got=%b want=%b", e.name, g, e.o);
         end
         total = total + 1;
         if (ifb.stall_cycles !== e.st) begin
            bad = bad + 1;
            $display("FAIL b:%s stall got=%0d want=%0d", e.name, ifb.stall_cycles, e.st);
         end
      end
   end

   initial begin
      in_t lu5;
      total   = 0;
      bad     = 0;
      stall_a = '0;
      stall_b = '0;
      tmo_b   = 1'b0;
      drive_a(I_IDLE);
      drive_b(I_IDLE);
      reset = 1'b1;
      #1 reset = 1'b0;

      // reset held with a divide request pending: no start, outputs forced
      for (int i = 0; i < 3; i++)
         step("reset", 1'b0, mi(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), I_IDLE, O_RST, O_RST);
      step("release", 1'b1, I_IDLE, I_IDLE, O_NORM, O_NORM);
      step("idle", 1'b1, I_IDLE, I_IDLE, O_NORM, O_NORM);

      // load-use on rs2: one bubble cycle, then normal with the stall counted
      lu5 = mi(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      step("lu_rs2", 1'b1, lu5, I_IDLE, O_LU, O_NORM);
      step("lu_after", 1'b1, I_IDLE, I_IDLE, O_NORM, O_NORM);

      // load to x0 and an unread operand never stall; a real rs1 match does
      step("x0_dest", 1'b1, mi(5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), I_IDLE, O_NORM, O_NORM);
      step("unused_rs1", 1'b1, mi(5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0), I_IDLE, O_NORM, O_NORM);
      step("lu_rs1", 1'b1, mi(5'd9, 5'd1, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0), I_IDLE, O_LU, O_NORM);
      step("lu_rs1_after", 1'b1, I_IDLE, I_IDLE, O_NORM, O_NORM);
      step("no_load", 1'b1, mi(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0), I_IDLE, O_NORM, O_NORM);

      // taken branch wins over a simultaneous load-use
      lu5.br = 1'b1;
      step("br_over_lu", 1'b1, lu5, I_IDLE, O_BR, O_NORM);
      step("br_after", 1'b1, I_IDLE, I_IDLE, O_NORM, O_NORM);

      // divide: start cycle, 32 held cycles (branch/load-use ignored), release with done on the 33rd
      step("div_start", 1'b1, mi(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), I_IDLE, O_DST, O_NORM);
      lu5.br = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         in_t v;
         v = I_IDLE;
         if (i == 4) v = lu5;
         if (i == 9) v.br = 1'b1;
         step("div_hold", 1'b1, v, I_IDLE, O_FRZ, O_NORM);
      end
      step("div_release", 1'b1, mi(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), I_IDLE, O_NORM, O_NORM);
      step("div_after", 1'b1, I_IDLE, I_IDLE, O_NORM, O_NORM);

      // watchdog on the 8-cycle controller: start, 7 held, forced release, then sticky timeout
      step("wd_start", 1'b1, I_IDLE, mi(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), O_NORM, O_DST);
      for (int i = 0; i < 7; i++)
         step("wd_hold", 1'b1, I_IDLE, I_IDLE, O_NORM, O_FRZ);
      step("wd_release", 1'b1, I_IDLE, I_IDLE, O_NORM, O_NORM);
      tmo_b = 1'b1;
      for (int i = 0; i < 3; i++)
         step("wd_sticky", 1'b1, I_IDLE, I_IDLE, O_NORM, O_NORM);
      // a load-use stall still works after the forced release
      step("wd_lu", 1'b1, I_IDLE, lu5, O_NORM, O_LU);
      step("wd_lu_after", 1'b1, I_IDLE, I_IDLE, O_NORM, O_NORM);

      // reset clears the timeout flag and both counters
      step("reset2", 1'b0, I_IDLE, I_IDLE, O_RST, O_RST);
      step("release2", 1'b1, I_IDLE, I_IDLE, O_NORM, O_NORM);
      step("idle2", 1'b1, I_IDLE, I_IDLE, O_NORM, O_NORM);

      for (int i = 0; i < 4 && (q_a.size() > 0 || q_b.size() > 0); i++)
         @(negedge clk);
      #1;
      if (q_a.size() > 0 || q_b.size() > 0) begin
         bad = bad + 1;
         $display("FAIL drain left=%0d want=0", q_a.size() + q_b.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
